seg7_scan_decoder: RTL

- Reads back a multiplexed, active-low 7-segment display bus (anode select plus shared cathode lines) and recovers the hex digits shown.
- Used as an on-board display monitor and as a bench checker for the display driver path.
- Holds a NDIGITS-nibble value register with per-digit valid, decimal-point and error indications, plus a frame-complete pulse.

---
 rtl/seg7_scan_decoder_if.sv | 22 ++
 rtl/seg7_scan_decoder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Display readback bus: sampled anode/cathode lines in, recovered digit state out.
interface seg7_scan_decoder_if #(
  parameter int NDIGITS = 4
);
  logic [NDIGITS-1:0]   anode;
  logic [7:0]           catode;
  logic [4*NDIGITS-1:0] value;
  logic [NDIGITS-1:0]   digit_valid;
  logic [NDIGITS-1:0]   dp;
  logic                 err;
  logic                 frame_valid;

  modport master (
    output anode, catode,
    input  value, digit_valid, dp, err, frame_valid
  );

  modport slave (
    input  anode, catode,
    output value, digit_valid, dp, err, frame_valid
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus by accepting
// each digit once its anode/cathode sample has been stable long enough.
module seg7_scan_decoder #(
  parameter int NDIGITS       = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  seg7_scan_decoder_if.slave bus
);
  localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [NDIGITS-1:0] ALL_ONES = '1;

  logic [NDIGITS-1:0] anode_reg, anode_prev_reg;
  logic [7:0]         catode_reg, catode_prev_reg;
  logic [7:0]         cnt_reg, cnt_next;
  logic               accepted_reg, accepted_next;
  logic               err_reg, frame_reg;

  logic [NDIGITS-1:0] lows;
  logic               single_low;
  logic [IDXW-1:0]    idx;
  logic               changed;
  logic               accept;
  logic [4:0]         decoded;
  logic               legal;
  logic [3:0]         nibble;
  logic               frame_due;

  wire [4*NDIGITS-1:0] value_w;
  wire [NDIGITS-1:0]   valid_w;
  wire [NDIGITS-1:0]   dp_w;
  wire [NDIGITS-1:0]   seen_w;

  // Returns {legal, nibble} for a segment pattern ordered A..G.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode = {1'b1, 4'h0};
      7'b1001111: decode = {1'b1, 4'h1};
      7'b0010010: decode = {1'b1, 4'h2};
      7'b0000110: decode = {1'b1, 4'h3};
      7'b1001100: decode = {1'b1, 4'h4};
      7'b0100100: decode = {1'b1, 4'h5};
      7'b0100000: decode = {1'b1, 4'h6};
      7'b0001111: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0000100: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b1100000: decode = {1'b1, 4'hB};
      7'b0110001: decode = {1'b1, 4'hC};
      7'b1000010: decode = {1'b1, 4'hD};
      7'b0110000: decode = {1'b1, 4'hE};
      7'b0111000: decode = {1'b1, 4'hF};
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    lows       = ~anode_reg;
    single_low = (lows != '0) && ((lows & (lows - NDIGITS'(1))) == '0);
    idx        = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (lows[i]) idx = IDXW'(i);
    end
    changed = (anode_reg != anode_prev_reg) || (catode_reg != catode_prev_reg);

    if (!single_low)          cnt_next = 8'd0;
    else if (changed)         cnt_next = 8'd1;
    else if (cnt_reg < STABLE) cnt_next = cnt_reg + 8'd1;
    else                      cnt_next = cnt_reg;

    // A fresh sample re-arms the accept even if the previous dwell already fired.
    accept        = single_low && (cnt_next == STABLE) && (changed || !accepted_reg);
    accepted_next = accept || (accepted_reg && single_low && !changed);

    decoded   = decode(catode_reg[7:1]);
    legal     = decoded[4];
    nibble    = decoded[3:0];
    frame_due = (seen_w == ALL_ONES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      anode_reg       <= '1;
      anode_prev_reg  <= '1;
      catode_reg      <= '0;
      catode_prev_reg <= '0;
      cnt_reg         <= 8'd0;
      accepted_reg    <= 1'b0;
      err_reg         <= 1'b0;
      frame_reg       <= 1'b0;
    end else begin
      anode_reg       <= bus.anode;
      anode_prev_reg  <= anode_reg;
      catode_reg      <= bus.catode;
      catode_prev_reg <= catode_reg;
      cnt_reg         <= cnt_next;
      accepted_reg    <= accepted_next;
      err_reg         <= accept && !legal;
      frame_reg       <= frame_due;
    end
  end

  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      logic [3:0] nib_reg;
      logic       valid_reg, dp_reg, seen_reg;
      logic       hit;

      assign hit = accept && (idx == IDXW'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          nib_reg   <= 4'h0;
          valid_reg <= 1'b0;
          dp_reg    <= 1'b0;
          seen_reg  <= 1'b0;
        end else begin
          if (hit) begin
            valid_reg <= legal;
            if (legal) begin
              nib_reg <= nibble;
              dp_reg  <= ~catode_reg[0];
            end
          end
          // The frame pulse clears the mask but keeps an accept landing on that edge.
          seen_reg <= (hit && legal) || (seen_reg && !frame_due);
        end
      end

      assign value_w[4*gi +: 4] = nib_reg;
      assign valid_w[gi]        = valid_reg;
      assign dp_w[gi]           = dp_reg;
      assign seen_w[gi]         = seen_reg;
    end
  endgenerate

  assign bus.value       = value_w;
  assign bus.digit_valid = valid_w;
  assign bus.dp          = dp_w;
  assign bus.err         = err_reg;
  assign bus.frame_valid = frame_reg;
endmodule
